// File: rtl/term_pkg.sv
// Shared screen geometry, control codes and writer state encoding for the
// terminal text buffer blocks.
package term_pkg;
  localparam int COLS   = 40;
  localparam int ROWS   = 24;
  localparam int SCREEN = COLS * ROWS;

  localparam logic [7:0] BLANK = 8'h20;

  localparam logic [7:0] BS = 8'h08;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] FF = 8'h0C;
  localparam logic [7:0] CR = 8'h0D;

  typedef enum logic [2:0] {
    IDLE,
    SCR_RD,
    SCR_WR,
    CLR_ROW,
    CLR_ALL
  } wr_state_e;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction
endpackage

// File: rtl/term_writer.sv
// Writes a character/control-code stream into the text buffer at the cursor,
// scrolling the screen up by one row when the cursor runs off the end.
module term_writer
  import term_pkg::*;
#(
  parameter int         COLS  = term_pkg::COLS,
  parameter int         ROWS  = term_pkg::ROWS,
  parameter int         AW    = 10,
  parameter logic [7:0] BLANK = term_pkg::BLANK
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    i_char,
  input  logic          i_char_v,
  output logic          o_ready,
  output logic          o_wen,
  output logic [AW-1:0] o_addr,
  output logic [7:0]    o_wdata,
  input  logic [7:0]    i_rdata,
  output logic [AW-1:0] o_cursor
);

  localparam logic [AW-1:0] L_ONE     = AW'(1);
  localparam logic [AW-1:0] L_COLS    = AW'(COLS);
  localparam logic [AW-1:0] L_COLM1   = AW'(COLS - 1);
  localparam logic [AW-1:0] L_LASTROW = AW'(COLS * (ROWS - 1));
  localparam logic [AW-1:0] L_SCR_END = AW'(COLS * (ROWS - 1) - 1);
  localparam logic [AW-1:0] L_LAST    = AW'(COLS * ROWS - 1);

  wr_state_e     r_state,  w_state;
  logic [AW-1:0] r_idx,    w_idx;
  logic [AW-1:0] r_cursor, w_cursor;
  logic [AW-1:0] r_col,    w_col;
  logic          r_wen,    w_wen;
  logic [AW-1:0] r_addr,   w_addr;
  logic [7:0]    r_wdata,  w_wdata;
  logic          r_rdsel,  w_rdsel;
  logic          w_accept;

  assign w_accept = i_char_v && (r_state == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_cursor <= '0;
      r_col    <= '0;
      r_wen    <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdsel  <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_idx    <= w_idx;
      r_cursor <= w_cursor;
      r_col    <= w_col;
      r_wen    <= w_wen;
      r_addr   <= w_addr;
      r_wdata  <= w_wdata;
      r_rdsel  <= w_rdsel;
    end
  end

  // The buffer port is driven one cycle behind the state that requested the
  // access, so the printable write that triggers a scroll gets the port first.
  // Scroll writes take their data straight from the read issued the cycle before.
  always_comb begin
    w_state  = r_state;
    w_idx    = r_idx;
    w_cursor = r_cursor;
    w_col    = r_col;
    w_wen    = 1'b0;
    w_addr   = r_addr;
    w_wdata  = r_wdata;
    w_rdsel  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (is_printable(i_char)) begin
            w_wen   = 1'b1;
            w_addr  = r_cursor;
            w_wdata = i_char;
            if (r_cursor == L_LAST) begin
              w_cursor = L_LASTROW;
              w_col    = '0;
              w_idx    = '0;
              w_state  = SCR_RD;
            end else begin
              w_cursor = r_cursor + L_ONE;
              w_col    = (r_col == L_COLM1) ? '0 : r_col + L_ONE;
            end
          end else begin
            case (i_char)
              CR: begin
                w_cursor = r_cursor - r_col;
                w_col    = '0;
              end
              LF: begin
                if (r_cursor < L_LASTROW) begin
                  w_cursor = r_cursor + L_COLS;
                end else begin
                  w_idx   = '0;
                  w_state = SCR_RD;
                end
              end
              BS: begin
                if (r_col != '0) begin
                  w_cursor = r_cursor - L_ONE;
                  w_col    = r_col - L_ONE;
                end
              end
              FF: begin
                w_cursor = '0;
                w_col    = '0;
                w_idx    = '0;
                w_state  = CLR_ALL;
              end
              default: ;
            endcase
          end
        end
      end
      SCR_RD: begin
        w_addr  = r_idx + L_COLS;
        w_state = SCR_WR;
      end
      SCR_WR: begin
        w_wen   = 1'b1;
        w_addr  = r_idx;
        w_rdsel = 1'b1;
        w_idx   = r_idx + L_ONE;
        w_state = (r_idx == L_SCR_END) ? CLR_ROW : SCR_RD;
      end
      CLR_ROW, CLR_ALL: begin
        w_wen   = 1'b1;
        w_addr  = r_idx;
        w_wdata = BLANK;
        if (r_idx == L_LAST) begin
          w_idx   = '0;
          w_state = IDLE;
        end else begin
          w_idx = r_idx + L_ONE;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  assign o_ready  = (r_state == IDLE);
  assign o_wen    = r_wen;
  assign o_addr   = r_addr;
  assign o_wdata  = r_rdsel ? i_rdata : r_wdata;
  assign o_cursor = r_cursor;

endmodule

// File: tb/tb_term_writer.sv
// Bench for term_writer: directed byte stream against a 1024x8 buffer model,
// with a scoreboard of expected buffer writes.
module tb_term_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] i_char;
  logic       i_char_v;
  logic       o_ready;
  logic       o_wen;
  logic [9:0] o_addr;
  logic [7:0] o_wdata;
  logic [7:0] i_rdata;
  logic [9:0] o_cursor;

  always #5 clk = ~clk;

  term_writer #(.COLS(40), .ROWS(24), .AW(10), .BLANK(8'h20)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_char   (i_char),
    .i_char_v (i_char_v),
    .o_ready  (o_ready),
    .o_wen    (o_wen),
    .o_addr   (o_addr),
    .o_wdata  (o_wdata),
    .i_rdata  (i_rdata),
    .o_cursor (o_cursor)
  );

  // Text buffer: one port, 1-cycle read latency, plus a bench preload path.
  logic [7:0] mem [1024];
  logic       pre_we;
  logic [9:0] pre_addr;
  logic [7:0] pre_data;

  always @(posedge clk) begin
    if (o_wen) mem[o_addr] <= o_wdata;
    else if (pre_we) mem[pre_addr] <= pre_data;
    i_rdata <= mem[o_addr];
  end

  typedef struct packed {
    logic [9:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        exp_q[$];
  int         nchk = 0;
  int         nerr = 0;
  logic [7:0] scr [1024];
  int         m_cur = 0;
  int         m_col = 0;

  always @(negedge clk) begin
    wr_t e;
    if (rst === 1'b1 && o_wen === 1'b1) begin
      nchk++;
      if (exp_q.size() == 0) begin
        nerr++;
        $display("FAIL wr_unexpected: got addr=%0d data=%02h, expected no write", o_addr, o_wdata);
      end else begin
        e = exp_q.pop_front();
        if (o_addr !== e.a || o_wdata !== e.d) begin
          nerr++;
          $display("FAIL wr_check: got addr=%0d data=%02h, expected addr=%0d data=%02h",
                   o_addr, o_wdata, e.a, e.d);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int a, input logic [7:0] d);
    wr_t e;
    e.a = 10'(a);
    e.d = d;
    exp_q.push_back(e);
    scr[a] = d;
  endtask

  task automatic model_scroll();
    for (int i = 0; i < 920; i++) push(i, scr[i + 40]);
    for (int i = 920; i < 960; i++) push(i, 8'h20);
  endtask

  task automatic model_char(input logic [7:0] c);
    if (c >= 8'h20 && c <= 8'h7E) begin
      push(m_cur, c);
      if (m_cur == 959) begin
        m_cur = 920;
        m_col = 0;
        model_scroll();
      end else begin
        m_cur++;
        m_col = (m_col == 39) ? 0 : m_col + 1;
      end
    end else if (c == 8'h0D) begin
      m_cur -= m_col;
      m_col = 0;
    end else if (c == 8'h0A) begin
      if (m_cur + 40 < 960) m_cur += 40;
      else model_scroll();
    end else if (c == 8'h08) begin
      if (m_col > 0) begin
        m_cur--;
        m_col--;
      end
    end else if (c == 8'h0C) begin
      for (int i = 0; i < 960; i++) push(i, 8'h20);
      m_cur = 0;
      m_col = 0;
    end
  endtask

  task automatic send(input logic [7:0] c);
    int n = 0;
    @(negedge clk);
    while (!o_ready && n < 4000) begin
      n++;
      @(negedge clk);
    end
    if (!o_ready) begin
      nchk++;
      nerr++;
      $display("FAIL send_ready: got o_ready=0 after %0d cycles, expected 1", n);
    end else begin
      model_char(c);
      i_char   = c;
      i_char_v = 1'b1;
      @(posedge clk);
      #1 i_char_v = 1'b0;
    end
  endtask

  task automatic wait_idle(output int busy);
    busy = 0;
    @(negedge clk);
    while (!o_ready && busy < 3000) begin
      busy++;
      @(negedge clk);
    end
    if (!o_ready) begin
      nchk++;
      nerr++;
      $display("FAIL idle_timeout: got o_ready=0 after %0d cycles, expected 1", busy);
    end
  endtask

  // mode 0: arbitrary pattern everywhere; mode 1: row r holds r+1, 0xA5 past the screen.
  task automatic preload(input int mode);
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      pre_we   = 1'b1;
      pre_addr = 10'(i);
      if (mode == 0) pre_data = 8'(i * 7 + 3);
      else pre_data = (i < 960) ? 8'(i / 40 + 1) : 8'hA5;
      scr[i] = pre_data;
    end
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy;
    rst      = 1'b0;
    i_char   = 8'h00;
    i_char_v = 1'b0;
    pre_we   = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    for (int i = 0; i < 1024; i++) scr[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ready",  o_ready,  1);
    chk("rst_wen",    o_wen,    0);
    chk("rst_addr",   o_addr,   0);
    chk("rst_wdata",  o_wdata,  0);
    chk("rst_cursor", o_cursor, 0);
    rst = 1'b1;

    send(8'h41);
    @(negedge clk);
    chk("A_cursor", o_cursor, 1);
    chk("A_ready",  o_ready,  1);

    send(8'h42);
    send(8'h43);
    send(8'h0D);
    send(8'h0A);
    @(negedge clk);
    chk("crlf_cursor", o_cursor, 40);
    chk("buf0", mem[0], 8'h41);
    chk("buf1", mem[1], 8'h42);
    chk("buf2", mem[2], 8'h43);

    send(8'h08);
    @(negedge clk);
    chk("bs_col0_cursor", o_cursor, 40);
    send(8'h58);
    @(negedge clk);
    chk("x_cursor", o_cursor, 41);
    send(8'h08);
    @(negedge clk);
    chk("bs1_cursor", o_cursor, 40);
    send(8'h08);
    @(negedge clk);
    chk("bs2_cursor", o_cursor, 40);
    chk("bs_no_erase", mem[40], 8'h58);
    send(8'h07);
    @(negedge clk);
    chk("ignored_cursor", o_cursor, 40);

    preload(0);
    send(8'h0C);
    wait_idle(busy);
    chk("ff_busy", busy, 960);
    @(negedge clk);
    @(negedge clk);
    chk("ff_cursor", o_cursor, 0);
    chk("ff_buf0",   mem[0],    8'h20);
    chk("ff_buf959", mem[959],  8'h20);
    chk("ff_buf960", mem[960],  8'h43);
    chk("ff_buf1023", mem[1023], 8'hFC);
    chk("ff_queue", exp_q.size(), 0);

    for (int i = 0; i < 23; i++) send(8'h0A);
    for (int i = 0; i < 39; i++) send(8'h2E);
    @(negedge clk);
    chk("pos_cursor", o_cursor, 959);
    preload(1);
    send(8'h5A);
    wait_idle(busy);
    chk("scroll_busy", busy, 1880);
    @(negedge clk);
    @(negedge clk);
    chk("scroll_cursor", o_cursor, 920);
    chk("scr_buf0",   mem[0],   2);
    chk("scr_buf39",  mem[39],  2);
    chk("scr_buf880", mem[880], 24);
    chk("scr_buf918", mem[918], 24);
    chk("scr_buf919", mem[919], 8'h5A);
    chk("scr_buf920", mem[920], 8'h20);
    chk("scr_buf959", mem[959], 8'h20);
    chk("scr_buf960", mem[960], 8'hA5);
    chk("scr_queue", exp_q.size(), 0);

    send(8'h0A);
    wait_idle(busy);
    chk("lf_scroll_busy", busy, 1880);
    @(negedge clk);
    @(negedge clk);
    chk("lf_scroll_cursor", o_cursor, 920);
    chk("lf_buf0",   mem[0],   3);
    chk("lf_buf840", mem[840], 24);
    chk("lf_buf879", mem[879], 8'h5A);
    chk("lf_buf880", mem[880], 8'h20);
    chk("lf_queue", exp_q.size(), 0);

    send(8'h0A);
    repeat (500) @(posedge clk);
    #2;
    rst = 1'b0;
    exp_q.delete();
    m_cur = 0;
    m_col = 0;
    #1;
    chk("midrst_wen",    o_wen,    0);
    chk("midrst_ready",  o_ready,  1);
    chk("midrst_cursor", o_cursor, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_wen",    o_wen,    0);
    chk("rel_ready",  o_ready,  1);
    chk("rel_cursor", o_cursor, 0);
    send(8'h51);
    @(negedge clk);
    @(negedge clk);
    chk("q_cursor", o_cursor, 1);
    chk("q_buf0",   mem[0],   8'h51);
    chk("final_queue", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
